// File: rtl/ir_pkg.sv
// Shared definitions for the instruction register and the control decoder.
package ir_pkg;

   // Default geometry of the instruction word
   localparam int IR_BUS_W     = 8;
   localparam int IR_NUM_BYTES = 2;
   localparam int IR_OPC_W     = 3;

   // Opcode encoding as seen by the control decoder
   typedef enum logic [IR_OPC_W-1:0] {
      OPC_NOP = 3'd0,
      OPC_LDA = 3'd1,
      OPC_STA = 3'd2,
      OPC_ADD = 3'd3,
      OPC_SUB = 3'd4,
      OPC_JMP = 3'd5,
      OPC_JZ  = 3'd6,
      OPC_HLT = 3'd7
   } ir_opcode_e;

   // Lane of the instruction word that beat k lands in
   function automatic int lane_of(input int k, input int num_bytes, input bit msb_first);
      return msb_first ? (num_bytes - 1 - k) : k;
   endfunction

endpackage

// File: rtl/ir_assembler.sv
// Instruction register: gathers NUM_BYTES bus beats into a shadow word and
// commits it atomically, then splits it into opcode and address fields.
module ir_assembler
   import ir_pkg::*;
#(
   parameter int BUS_W     = IR_BUS_W,
   parameter int NUM_BYTES = IR_NUM_BYTES,
   parameter int OPC_W     = IR_OPC_W,
   parameter bit MSB_FIRST = 1'b1,
   localparam int IR_W     = BUS_W * NUM_BYTES,
   localparam int ADDR_W   = IR_W - OPC_W,
   localparam int IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENA,
   input  logic [BUS_W-1:0]  DATA,
   output logic [OPC_W-1:0]  OPCODE,
   output logic [ADDR_W-1:0] IR_ADDR,
   output logic              IR_VALID,
   output logic              LOAD_DONE,
   output logic              ABORT,
   output logic [IDX_W-1:0]  BYTE_IDX
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   logic [IR_W-1:0] shadow;
   logic [IR_W-1:0] ir;
   logic [IR_W-1:0] merged;
   logic            last_beat;
   int              lane;

   assign last_beat = (BYTE_IDX == LAST_IDX);
   assign lane      = lane_of(int'(BYTE_IDX), NUM_BYTES, MSB_FIRST);

   // Shadow word with the current beat dropped into its lane
   always_comb begin
      // NOTE: assign a full default first so no path leaves merged unassigned (no latch).
      merged = shadow;
      merged[lane*BUS_W +: BUS_W] = DATA;
   end

   // Beat counter and shadow register: advance on each beat, clear on commit or abandon
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         BYTE_IDX <= '0;
         shadow   <= '0;
      end else if (ENA) begin
         if (last_beat) begin
            BYTE_IDX <= '0;
            shadow   <= '0;
         end else begin
            BYTE_IDX <= BYTE_IDX + IDX_W'(1);
            shadow   <= merged;
         end
      end else if (BYTE_IDX != '0) begin
         BYTE_IDX <= '0;
         shadow   <= '0;
      end
   end

   // Commit register: takes the completed word in one edge, sticky valid flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         ir       <= '0;
         IR_VALID <= 1'b0;
      end else if (ENA && last_beat) begin
         ir       <= merged;
         IR_VALID <= 1'b1;
      end
   end

   // Status pulses: one cycle each, never together
   always_ff @(posedge CLK) begin
      if (RST) begin
         LOAD_DONE <= 1'b0;
         ABORT     <= 1'b0;
      end else begin
         LOAD_DONE <= ENA && last_beat;
         ABORT     <= !ENA && (BYTE_IDX != '0);
      end
   end

   assign OPCODE  = ir[OPC_W-1:0];
   assign IR_ADDR = ir[IR_W-1:OPC_W];

endmodule
